// File: rtl/led_rgb_sequencer.sv
// led_rgb_sequencer: steps a DEPTH-entry pattern table onto the RGB LED core config, holding each entry (dwell+1)*PRESCALE cycles.
// Optional macro LED_SEQ_SYNC_RESET_EN adds led_resetn, driven low during each entry's APPLY cycle.
module led_rgb_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int PRESCALE = 1000
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic [AW:0]   num_entries,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic          mode_r,
  output logic          mode_g,
  output logic          mode_b,
  output logic          enable_r,
  output logic          enable_g,
  output logic          enable_b,
  output logic          holded_r,
  output logic          holded_g,
  output logic          holded_b,
  output logic [31:0]   duration_r,
  output logic [31:0]   duration_g,
  output logic [31:0]   duration_b,
  output logic          busy,
  output logic [AW-1:0] cur_idx,
`ifdef LED_SEQ_SYNC_RESET_EN
  output logic          led_resetn,
`endif
  output logic          done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, APPLY, DWELL} state_t;

  state_t        state;
  logic [60:0]   mem [DEPTH];
  logic [60:0]   rd_q;
  logic [AW-1:0] idx;
  logic [19:0]   dwell_cnt;
  logic [PW-1:0] pre;
  logic [2:0]    en_q, md_q, hd_q;
  logic [31:0]   dur_q;
  logic [AW:0]   n_eff, idx_nxt;
  logic          unused_rsvd;

  assign unused_rsvd = ^wr_data[43:41];
  assign n_eff   = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
  assign idx_nxt = {1'b0, idx} + (AW+1)'(1);

  // Table stores {dwell, holded, mode, enable, duration}; reserved bits are dropped.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= {wr_data[63:44], wr_data[40:0]};
    if (state == LOAD) rd_q <= mem[idx];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      idx       <= '0;
      cur_idx   <= '0;
      dwell_cnt <= '0;
      pre       <= '0;
      en_q      <= '0;
      md_q      <= '0;
      hd_q      <= '0;
      dur_q     <= '0;
      done      <= 1'b0;
`ifdef LED_SEQ_SYNC_RESET_EN
      led_resetn <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
`ifdef LED_SEQ_SYNC_RESET_EN
      led_resetn <= 1'b1;
`endif
      if (state != IDLE && stop) begin
        state     <= IDLE;
        cur_idx   <= '0;
        dwell_cnt <= '0;
        pre       <= '0;
        en_q      <= '0;
        md_q      <= '0;
        hd_q      <= '0;
        dur_q     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              if (n_eff != '0) begin
                idx   <= '0;
                state <= LOAD;
              end else begin
                done <= 1'b1;
              end
            end
          end
          LOAD: begin
            state <= APPLY;
`ifdef LED_SEQ_SYNC_RESET_EN
            led_resetn <= 1'b0;
`endif
          end
          APPLY: begin
            {dwell_cnt, hd_q, md_q, en_q, dur_q} <= rd_q;
            cur_idx <= idx;
            pre     <= '0;
            state   <= DWELL;
          end
          default: begin
            if (pre == PRE_MAX) begin
              pre <= '0;
              if (dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - 20'd1;
              end else if (idx_nxt < n_eff) begin
                idx   <= idx_nxt[AW-1:0];
                state <= LOAD;
              end else if (loop_en) begin
                idx   <= '0;
                state <= LOAD;
              end else begin
                state   <= IDLE;
                done    <= 1'b1;
                cur_idx <= '0;
                en_q    <= '0;
                md_q    <= '0;
                hd_q    <= '0;
                dur_q   <= '0;
              end
            end else begin
              pre <= pre + PW'(1);
            end
          end
        endcase
      end
    end
  end

  // Field bit 2 is red, bit 0 is blue.
  assign {enable_r, enable_g, enable_b} = en_q;
  assign {mode_r, mode_g, mode_b}       = md_q;
  assign {holded_r, holded_g, holded_b} = hd_q;
  assign duration_r = dur_q;
  assign duration_g = dur_q;
  assign duration_b = dur_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_led_rgb_sequencer.sv
// Bench for led_rgb_sequencer: vector table, hand sequences, and randomized runs against a timeline model.
module tb_led_rgb_sequencer;
  localparam int P = 4;
  localparam int D = 16;
  localparam logic [127:0] LRBIT = 128'b1 << 111;

  logic aclk = 1'b0, aresetn = 1'b0, wr_en = 1'b0, loop_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  num_entries = '0;
  logic mode_r, mode_g, mode_b, enable_r, enable_g, enable_b, holded_r, holded_g, holded_b;
  logic [31:0] duration_r, duration_g, duration_b;
  logic busy, done;
  logic [3:0] cur_idx;
`ifdef LED_SEQ_SYNC_RESET_EN
  logic led_resetn;
`endif

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0]  tbl [D];
  logic [127:0] exp_q [$];

  typedef struct {
    logic [63:0]  ent;
    int           n;
    bit           lp;
    int           k;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [11];

  led_rgb_sequencer #(.DEPTH(D), .AW(4), .PRESCALE(P)) dut (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_entries(num_entries), .loop_en(loop_en), .start(start), .stop(stop),
    .mode_r(mode_r), .mode_g(mode_g), .mode_b(mode_b),
    .enable_r(enable_r), .enable_g(enable_g), .enable_b(enable_b),
    .holded_r(holded_r), .holded_g(holded_g), .holded_b(holded_b),
    .duration_r(duration_r), .duration_g(duration_g), .duration_b(duration_b),
    .busy(busy), .cur_idx(cur_idx),
`ifdef LED_SEQ_SYNC_RESET_EN
    .led_resetn(led_resetn),
`endif
    .done(done)
  );

  always #5 aclk = ~aclk;

  function automatic logic [63:0] mk(logic [2:0] en, logic [2:0] md, logic [2:0] hd, logic [31:0] dur, int dwell);
    logic [19:0] dw = 20'(dwell);
    return {dw, 3'b000, hd, md, en, dur};
  endfunction

  function automatic logic [127:0] pk(logic b, logic dn, logic lr, logic [3:0] idx, logic [63:0] e);
    return {16'b0, lr, b, dn, idx, e[34:32], e[37:35], e[40:38], e[31:0], e[31:0], e[31:0]};
  endfunction

  function automatic logic [127:0] obs();
    logic lr = 1'b1;
`ifdef LED_SEQ_SYNC_RESET_EN
    lr = led_resetn;
`endif
    return {16'b0, lr, busy, done, cur_idx, enable_r, enable_g, enable_b, mode_r, mode_g, mode_b,
            holded_r, holded_g, holded_b, duration_r, duration_g, duration_b};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_entry(int a, logic [63:0] v);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = v;
    tick();
    wr_en = 1'b0;
    tbl[a] = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  // Expected per-cycle outputs after the start edge (k = 0), derived from the entry timeline:
  // entry e applied at t_e, next at t_e + (dwell+1)*P + 2, first at 2.
  task automatic build_model(int n_raw, bit lp, int s, int len);
    int n = (n_raw > D) ? D : n_raw;
    int e = 0, t = 2, seg_end = -1, cidx = 0;
    bit ended = 1'b0, dn, lr;
    logic [63:0] cur = '0;
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      dn = 1'b0;
      if (!ended && k == s) begin
        ended = 1'b1; cur = '0; cidx = 0;
      end else if (!ended && k == seg_end) begin
        if (e + 1 < n) begin e++; t = k + 2; end
        else if (lp) begin e = 0; t = k + 2; end
        else begin ended = 1'b1; cur = '0; cidx = 0; dn = 1'b1; end
      end else if (!ended && k == t) begin
        cur = tbl[e]; cidx = e;
        seg_end = k + (int'(cur[63:44]) + 1) * P;
      end
      lr = 1'b1;
`ifdef LED_SEQ_SYNC_RESET_EN
      lr = !(!ended && t == k + 1);
`endif
      exp_q.push_back(pk(!ended, dn, lr, 4'(cidx), cur));
    end
  endtask

  task automatic run_check(string tag, int n_raw, bit lp, int s, int len, bit rnd_start);
    build_model(n_raw, lp, s, len);
    num_entries = 5'(n_raw);
    loop_en = lp;
    pulse_start();
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s_k%0d", tag, k), obs(), exp_q[k]);
      stop  = (k + 1 == s);
      start = rnd_start && exp_q[k][110] && ($urandom_range(0, 3) == 0);
      tick();
    end
    stop = 1'b0;
    start = 1'b0;
    go_idle();
  endtask

  initial begin
    logic [63:0] e1, e2, ea, eb, ec, v;
    int n_raw, s;
    bit lp;
    e1 = mk(3'b101, 3'b001, 3'b000, 32'd100, 2);
    e2 = mk(3'b111, 3'b110, 3'b011, 32'hDEADBEEF, 0);
    vecs[0]  = '{e1, 1, 1'b0, 1,  pk(1, 0, 0, 0, '0)};
    vecs[1]  = '{e1, 1, 1'b0, 2,  pk(1, 0, 0, 0, e1)};
    vecs[2]  = '{e1, 1, 1'b0, 13, pk(1, 0, 0, 0, e1)};
    vecs[3]  = '{e1, 1, 1'b0, 14, pk(0, 1, 0, 0, '0)};
    vecs[4]  = '{e1, 1, 1'b0, 15, pk(0, 0, 0, 0, '0)};
    vecs[5]  = '{e2, 1, 1'b0, 5,  pk(1, 0, 0, 0, e2)};
    vecs[6]  = '{e2, 1, 1'b0, 6,  pk(0, 1, 0, 0, '0)};
    vecs[7]  = '{e2, 0, 1'b0, 0,  pk(0, 1, 0, 0, '0)};
    vecs[8]  = '{e2, 0, 1'b0, 1,  pk(0, 0, 0, 0, '0)};
    vecs[9]  = '{e2, 1, 1'b1, 7,  pk(1, 0, 0, 0, e2)};
    vecs[10] = '{e2, 1, 1'b1, 9,  pk(1, 0, 0, 0, e2)};

    #11;
    check("reset_state", obs(), pk(0, 0, 1, 0, '0));
    #1 aresetn = 1'b1;
    tick();

    foreach (vecs[i]) begin
      write_entry(0, vecs[i].ent);
      num_entries = 5'(vecs[i].n);
      loop_en = vecs[i].lp;
      pulse_start();
      repeat (vecs[i].k) tick();
      check($sformatf("vec%0d", i), obs() & ~LRBIT, vecs[i].exp & ~LRBIT);
      go_idle();
    end

    // Asynchronous reset in the middle of a dwell clears everything immediately.
    write_entry(0, e1);
    num_entries = 5'd1; loop_en = 1'b0;
    pulse_start();
    repeat (5) tick();
    check("pre_reset", obs() & ~LRBIT, pk(1, 0, 0, 0, e1) & ~LRBIT);
    #2 aresetn = 1'b0;
    #1 check("mid_dwell_reset", obs(), pk(0, 0, 1, 0, '0));
    #2 aresetn = 1'b1;
    tick();

    write_entry(0, mk(3'b001, 3'b000, 3'b010, 32'd7, 0));
    write_entry(1, mk(3'b010, 3'b101, 3'b000, 32'd8, 0));
    write_entry(2, mk(3'b100, 3'b011, 3'b111, 32'd9, 0));
    run_check("loop3", 3, 1'b1, -1, 40, 1'b1);

    write_entry(0, e2);
    run_check("stop_end", 1, 1'b0, 6, 10, 1'b0);

    // Rewriting the entry being dwelt on only shows up on its next load.
    ea = mk(3'b001, 3'b010, 3'b100, 32'd11, 1);
    eb = mk(3'b010, 3'b001, 3'b111, 32'd22, 1);
    ec = mk(3'b100, 3'b100, 3'b001, 32'd33, 1);
    write_entry(0, ea);
    write_entry(1, eb);
    num_entries = 5'd2; loop_en = 1'b1;
    pulse_start();
    repeat (14) tick();
    write_entry(1, ec);
    tick();
    check("rewrite_hold", obs() & ~LRBIT, pk(1, 0, 0, 1, eb) & ~LRBIT);
    repeat (15) tick();
    check("rewrite_e0", obs() & ~LRBIT, pk(1, 0, 0, 0, ea) & ~LRBIT);
    tick();
    check("rewrite_new", obs() & ~LRBIT, pk(1, 0, 0, 1, ec) & ~LRBIT);
    go_idle();

    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < D; a++) begin
        v = mk(3'($urandom), 3'($urandom), 3'($urandom), $urandom, $urandom_range(0, 3));
        v[43:41] = 3'($urandom);
        write_entry(a, v);
      end
      n_raw = $urandom_range(1, 20);
      lp = 1'($urandom);
      s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 120) : -1;
      run_check($sformatf("rnd%0d", r), n_raw, lp, s, 120, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_rgb_sequencer.md
Name: led_rgb_sequencer

Overview:
Pattern scheduler that drives the configuration inputs of the RGB LED core (mode/enable/holded/duration per channel) from a small on-chip pattern table. Software fills the table and starts it. The block then steps through the entries, holding each for a programmable dwell time, and either wraps or stops. It sits between the AXI-lite register file and the LED core and replaces static register control when enabled.

Parameters:
DEPTH, 16, pattern table entries (power of 2, 2..256)
AW, 4, table address width, equal to log2(DEPTH)
PRESCALE, 1000, aclk cycles per dwell tick (>=1)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  AW  table write address
wr_data  in  64  entry: [31:0] duration, [34:32] enable RGB, [37:35] mode RGB, [40:38] holded RGB, [43:41] reserved, [63:44] dwell ticks
num_entries  in  AW+1  active entries, 0..DEPTH
loop_en  in  1  1 = wrap to entry 0 after the last entry
start  in  1  single-cycle start pulse
stop  in  1  single-cycle abort pulse
mode_r/mode_g/mode_b  out  1 each  to LED core
enable_r/enable_g/enable_b  out  1 each  to LED core
holded_r/holded_g/holded_b  out  1 each  to LED core
duration_r/duration_g/duration_b  out  32 each  to LED core; all three carry the entry duration
busy  out  1  high in LOAD/APPLY/DWELL
cur_idx  out  AW  index of the entry currently applied
done  out  1  one-cycle pulse when a non-looping sequence completes

Behaviour:
- Reset (aresetn low, asynchronous): state IDLE. All enable/mode/holded = 0, durations = 0, busy = 0, cur_idx = 0, done = 0, prescaler and dwell counters = 0. Table contents are not reset.
- Table: DEPTH x 64 synchronous-read RAM. A write lands at the clock edge. Writes are accepted in any state. A write to the entry being dwelt on has no effect until that entry is next loaded.
- States and transitions:
  - IDLE: on start with num_entries != 0, go to LOAD with idx = 0. On start with num_entries == 0, pulse done and stay in IDLE.
  - LOAD: issue the table read for idx (1 cycle).
  - APPLY: register the read data into all outputs and set cur_idx = idx. Load dwell_cnt = dwell field and clear the prescaler. Go to DWELL.
  - DWELL: the prescaler counts 0..PRESCALE-1. At PRESCALE-1: if dwell_cnt == 0 the entry ends, else dwell_cnt decrements. Total dwell = (dwell+1)*PRESCALE cycles, so a dwell field of 0 gives PRESCALE cycles.
  - Entry end: if idx+1 < num_entries, set idx+1 and go to LOAD. Otherwise, with loop_en = 1, set idx = 0 and go to LOAD. Otherwise go to IDLE, pulse done, and clear all outputs.
- Latency: start sampled at edge N, outputs valid after edge N+2. Successive entries are spaced by dwell + 2 cycles (LOAD + APPLY).
- stop has priority over start and over entry end in the same cycle. In any non-IDLE state, the next state is IDLE, outputs are cleared, done is not pulsed, and busy drops after the same edge.
- start while busy is ignored.
- num_entries is sampled at each entry end, so a runtime change takes effect at the next boundary. num_entries > DEPTH is clamped to DEPTH.
- loop_en is sampled at the last-entry boundary.
- Outputs hold steady for the whole dwell; no glitches between LOAD and APPLY.

Optional Feature:
LED_SEQ_SYNC_RESET_EN
- Defined: adds output led_resetn (1 bit, reset value 1). It drives low for exactly one cycle, the APPLY cycle of every entry, so the LED core's blink counters restart phase-aligned with each new pattern. The integrator ANDs it with the register-file user reset.
- Undefined: the port is absent, and the LED core keeps free-running phase across entries.

Test Plan:
- Reset mid-DWELL with outputs active -> all outputs 0, busy 0, done 0, in the same cycle aresetn falls.
- PRESCALE=4; write entry0 {enable=3'b101, mode=3'b001, holded=0, duration=100, dwell=2}; num_entries=1, loop_en=0; start -> enable_r=enable_b=1 from edge N+2 for exactly 12 cycles, then outputs 0, done=1 for 1 cycle, busy 0.
- Three entries with dwell 0, loop_en=1, PRESCALE=4 -> cur_idx sequence 0,1,2,0,1,..., new entry every 6 cycles, done never asserted.
- stop and entry end in the same cycle -> state IDLE, outputs cleared, no done pulse. start with num_entries=0 -> done pulse, busy stays 0.
- Rewrite entry1 while entry1 is dwelling (loop mode) -> current outputs unchanged; new values appear on the next pass at entry1 APPLY.
- With LED_SEQ_SYNC_RESET_EN, two-entry loop -> led_resetn low exactly one cycle coincident with each cur_idx update, high otherwise.
